// File: rtl/x3q_core_p.sv
// x3q_core_p: multi-cycle x3q CPU core with a req/ack memory port, interrupts,
// saved return PC, interrupt enable, flags register and illegal-opcode traps.
module x3q_core_p #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(0),
    parameter logic [DATA_W-1:0] IRQ_VEC   = DATA_W'(4),
    parameter logic [DATA_W-1:0] TRAP_VEC  = DATA_W'(8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              irq_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              irq_ack,
    output logic              trap,
    output logic [DATA_W-1:0] pc_o
);
    localparam int unsigned IW    = 16;
    localparam int unsigned NREG  = 8;
    localparam int unsigned SHAMT = DATA_W - 9;

    localparam logic [3:0] OP_NOP = 4'd0, OP_ALU = 4'd1, OP_ALUI = 4'd2, OP_JMP = 4'd4;
    localparam logic [3:0] OP_LD = 4'd5, OP_ST = 4'd6, OP_LUI = 4'd7, OP_RETI = 4'd8, OP_IE = 4'd9;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1;

    typedef enum logic [1:0] {S_FETCH, S_IWAIT, S_EXEC, S_DWAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_pc, w_pc_nxt, r_epc, w_epc_nxt;
    logic              r_ie, w_ie_nxt;
    logic [3:0]        r_flags, w_flags_nxt;   // {C, Z, EQ, GT}
    logic [IW-1:0]     r_ir, w_ir_nxt;
    logic [DATA_W-1:0] r_rf [NREG];
    logic              r_mem_req, w_mem_req_nxt, r_mem_we, w_mem_we_nxt;
    logic [DATA_W-1:0] r_mem_addr, w_mem_addr_nxt, r_mem_wdata, w_mem_wdata_nxt;
    logic              r_irq_ack, w_irq_ack_nxt, r_trap, w_trap_nxt;
    logic              w_rf_we;
    logic [2:0]        w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    logic [3:0] w_op;
    logic [2:0] w_s, w_ra, w_rb, w_rd;
    logic [7:0] w_imm8;
    logic [8:0] w_imm9;
    assign w_op   = r_ir[3:0];
    assign w_s    = r_ir[6:4];
    assign w_ra   = r_ir[9:7];
    assign w_rb   = r_ir[12:10];
    assign w_rd   = r_ir[15:13];
    assign w_imm8 = r_ir[15:8];
    assign w_imm9 = r_ir[15:7];

    logic [DATA_W-1:0] w_ra_val, w_rb_val, w_pc_inc;
    assign w_ra_val = (w_ra == 3'd0) ? '0 : r_rf[w_ra];
    assign w_rb_val = (w_rb == 3'd0) ? '0 : r_rf[w_rb];
    assign w_pc_inc = r_pc + DATA_W'(1);

    // ALU operand select: ALUI reuses the ALU with r2 and the zero-extended immediate
    logic [DATA_W-1:0] w_alu_a, w_alu_b, w_alu_res;
    logic [2:0]        w_alu_sel;
    logic [DATA_W:0]   w_sum, w_diff;
    logic              w_alu_c;
    logic [3:0]        w_alu_flags;

    always_comb begin
        w_alu_a   = w_ra_val;
        w_alu_b   = w_rb_val;
        w_alu_sel = w_s;
        if (w_op == OP_ALUI) begin
            w_alu_a   = r_rf[2];
            w_alu_b   = DATA_W'(w_imm8);
            w_alu_sel = w_s[0] ? ALU_SUB : ALU_ADD;
        end
    end

    assign w_sum  = {1'b0, w_alu_a} + {1'b0, w_alu_b};
    assign w_diff = {1'b0, w_alu_a} - {1'b0, w_alu_b};

    always_comb begin
        w_alu_c   = 1'b0;
        w_alu_res = '0;
        case (w_alu_sel)
            3'd0: begin w_alu_res = w_sum[DATA_W-1:0];  w_alu_c = w_sum[DATA_W];  end
            3'd1: begin w_alu_res = w_diff[DATA_W-1:0]; w_alu_c = w_diff[DATA_W]; end
            3'd2: w_alu_res = w_alu_a & w_alu_b;
            3'd3: w_alu_res = w_alu_a | w_alu_b;
            3'd4: w_alu_res = w_alu_a ^ w_alu_b;
            3'd5: w_alu_res = {w_alu_a[DATA_W-2:0], 1'b0};
            3'd6: w_alu_res = {1'b0, w_alu_a[DATA_W-1:1]};
            default: w_alu_res = DATA_W'(w_alu_a < w_alu_b);
        endcase
    end

    assign w_alu_flags = {w_alu_c, (w_alu_res == '0), (w_alu_a == w_alu_b), (w_alu_a > w_alu_b)};

    logic w_cond;
    always_comb begin
        w_cond = 1'b0;
        case (w_s)
            3'd0: w_cond = 1'b1;
            3'd1: w_cond = r_flags[2];
            3'd2: w_cond = r_flags[0];
            3'd3: w_cond = ~r_flags[0];
            3'd4: w_cond = r_flags[1];
            3'd5: w_cond = r_flags[3];
            3'd6: w_cond = ~r_flags[2];
            default: w_cond = 1'b0;
        endcase
    end

    // Next-state and next-output logic; memory address/data hold until the next request
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_epc_nxt       = r_epc;
        w_ie_nxt        = r_ie;
        w_flags_nxt     = r_flags;
        w_ir_nxt        = r_ir;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_irq_ack_nxt   = 1'b0;
        w_trap_nxt      = 1'b0;
        w_rf_we         = 1'b0;
        w_rf_waddr      = w_rd;
        w_rf_wdata      = '0;
        case (r_state)
            S_FETCH: begin
                if (r_ie && irq_in) begin
                    w_epc_nxt     = r_pc;
                    w_pc_nxt      = IRQ_VEC;
                    w_ie_nxt      = 1'b0;
                    w_irq_ack_nxt = 1'b1;
                end else begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = r_pc;
                    w_state_nxt    = S_IWAIT;
                end
            end
            S_IWAIT: begin
                if (mem_ack && !r_mem_req) begin
                    w_ir_nxt    = mem_rdata[IW-1:0];
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = w_pc_inc;
                case (w_op)
                    OP_NOP: ;
                    OP_ALU, OP_ALUI: begin
                        w_rf_we     = 1'b1;
                        w_rf_waddr  = (w_op == OP_ALUI) ? 3'd2 : w_rd;
                        w_rf_wdata  = w_alu_res;
                        w_flags_nxt = w_alu_flags;
                    end
                    OP_JMP: begin
                        w_pc_nxt   = w_cond ? w_ra_val : w_pc_inc;
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_pc_inc;
                    end
                    OP_LD, OP_ST: begin
                        w_pc_nxt        = r_pc;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = (w_op == OP_ST);
                        w_mem_addr_nxt  = w_ra_val;
                        w_mem_wdata_nxt = (w_op == OP_ST) ? w_rb_val : r_mem_wdata;
                        w_state_nxt     = S_DWAIT;
                    end
                    OP_LUI: begin
                        w_rf_we    = 1'b1;
                        w_rf_waddr = w_s;
                        w_rf_wdata = DATA_W'(w_imm9) << SHAMT;
                    end
                    OP_RETI: begin
                        w_pc_nxt = r_epc;
                        w_ie_nxt = 1'b1;
                    end
                    OP_IE: w_ie_nxt = w_s[0];
                    default: begin
                        w_epc_nxt  = r_pc;
                        w_pc_nxt   = TRAP_VEC;
                        w_ie_nxt   = 1'b0;
                        w_trap_nxt = 1'b1;
                    end
                endcase
            end
            default: begin
                if (mem_ack && !r_mem_req) begin
                    w_rf_we     = ~r_mem_we;
                    w_rf_wdata  = mem_rdata;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_VEC;
            r_epc       <= '0;
            r_ie        <= 1'b0;
            r_flags     <= '0;
            r_ir        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_irq_ack   <= 1'b0;
            r_trap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_epc       <= w_epc_nxt;
            r_ie        <= w_ie_nxt;
            r_flags     <= w_flags_nxt;
            r_ir        <= w_ir_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_irq_ack   <= w_irq_ack_nxt;
            r_trap      <= w_trap_nxt;
        end
    end

    // r0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf <= '{default: '0};
        end else if (w_rf_we && (w_rf_waddr != 3'd0)) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign irq_ack   = r_irq_ack;
    assign trap      = r_trap;
    assign pc_o      = r_pc;
endmodule

// File: tb/tb_x3q_core_p.sv
// Testbench for x3q_core_p: small programs run against a memory model; stores,
// PC, irq_ack and trap are compared with hand-computed values.
module tb_x3q_core_p;
    localparam logic [3:0] OP_ALU = 4'd1, OP_ALUI = 4'd2, OP_JMP = 4'd4, OP_LD = 4'd5;
    localparam logic [3:0] OP_ST = 4'd6, OP_LUI = 4'd7, OP_RETI = 4'd8, OP_IE = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        reset16, ack16, irq16, req16, we16, irqack16, trap16;
    logic [15:0] rdata16, addr16, wdata16, pc16;
    x3q_core_p #(.DATA_W(16)) u_dut16 (
        .clk(clk), .reset(reset16), .mem_rdata(rdata16), .mem_ack(ack16), .irq_in(irq16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .irq_ack(irqack16), .trap(trap16), .pc_o(pc16));

    // 32-bit instance
    logic        reset32, ack32, irq32, req32, we32, irqack32, trap32;
    logic [31:0] rdata32, addr32, wdata32, pc32;
    x3q_core_p #(.DATA_W(32)) u_dut32 (
        .clk(clk), .reset(reset32), .mem_rdata(rdata32), .mem_ack(ack32), .irq_in(irq32),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
        .irq_ack(irqack32), .trap(trap32), .pc_o(pc32));

    // Memory models: program arrays loaded by the test, stores logged and overlaid
    logic [15:0]   mem16 [0:1023];
    logic [15:0]   dmem16 [0:1023];
    logic [1023:0] dvalid16;
    logic [15:0]   wa16 [0:127];
    logic [15:0]   wd16 [0:127];
    int            wcnt16 = 0;
    logic [31:0]   mem32 [0:63];
    logic [31:0]   wa32 [0:15];
    logic [31:0]   wd32 [0:15];
    int            wcnt32 = 0;

    always @(posedge clk) begin
        ack16 <= 1'b0;
        if (reset16) dvalid16 <= '0;
        else if (req16) begin
            ack16 <= 1'b1;
            if (we16) begin
                dmem16[addr16[9:0]]   <= wdata16;
                dvalid16[addr16[9:0]] <= 1'b1;
                wa16[wcnt16[6:0]]     <= addr16;
                wd16[wcnt16[6:0]]     <= wdata16;
                wcnt16                <= wcnt16 + 1;
            end else begin
                rdata16 <= dvalid16[addr16[9:0]] ? dmem16[addr16[9:0]] : mem16[addr16[9:0]];
            end
        end
    end

    always @(posedge clk) begin
        ack32 <= 1'b0;
        if (req32 && !reset32) begin
            ack32 <= 1'b1;
            if (we32) begin
                wa32[wcnt32[3:0]] <= addr32;
                wd32[wcnt32[3:0]] <= wdata32;
                wcnt32            <= wcnt32 + 1;
            end else begin
                rdata32 <= mem32[addr32[5:0]];
            end
        end
    end

    typedef struct {
        logic [2:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [2:0]  jc;
        logic        taken;
    } vec_t;

    vec_t        vt [12];
    int          checks = 0;
    int          errors = 0;
    int          pa;
    int          wbase;
    logic [15:0] exp_d [$];
    logic [15:0] tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [15:0] ea, input logic [15:0] ed);
        if (idx >= wcnt16) begin
            checks++;
            errors++;
            $display("FAIL %s: store %0d missing (only %0d stores)", name, idx, wcnt16);
        end else begin
            chk({name, " addr"}, 32'(wa16[idx[6:0]]), 32'(ea));
            chk({name, " data"}, 32'(wd16[idx[6:0]]), 32'(ed));
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] s,
                                        input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd);
        return {rd, rb, ra, s, op};
    endfunction

    function automatic logic [15:0] enc_alui(input logic sub, input logic [7:0] imm);
        return {imm, 1'b0, 2'b00, sub, OP_ALUI};
    endfunction

    function automatic logic [15:0] enc_lui(input logic [2:0] rd, input logic [8:0] imm);
        return {imm, rd, OP_LUI};
    endfunction

    task automatic emit(input logic [15:0] w);
        mem16[pa[9:0]] = w;
        pa = pa + 1;
    endtask

    task automatic load_const(input logic [2:0] rd, input logic [15:0] v);
        emit(enc_lui(3'd2, v[15:7]));
        emit(enc_alui(1'b0, {1'b0, v[6:0]}));
        if (rd != 3'd2) emit(enc(OP_ALU, 3'd3, 3'd2, 3'd0, rd));
    endtask

    // Park the core: r7 <= own address + 1, then jump to r7 forever
    task automatic emit_halt();
        emit(enc(OP_JMP, 3'd7, 3'd0, 3'd0, 3'd7));
        emit(enc(OP_JMP, 3'd0, 3'd7, 3'd0, 3'd0));
    endtask

    task automatic prep16();
        reset16 = 1'b1;
        irq16   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
        pa    = 0;
        wbase = wcnt16;
    endtask

    task automatic wait_writes16(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (wcnt16 >= target) break;
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        reset16 = 1'b1; reset32 = 1'b1; irq16 = 1'b0; irq32 = 1'b0;
        for (int i = 0; i < 64; i++) mem32[i] = 32'h0;
        vt[0]  = '{3'd0, 16'h0005, 16'h0080, 16'h0085, 3'd5, 1'b0};
        vt[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'd5, 1'b1};
        vt[2]  = '{3'd1, 16'h0003, 16'h0003, 16'h0000, 3'd4, 1'b1};
        vt[3]  = '{3'd1, 16'h0002, 16'h0005, 16'hFFFD, 3'd5, 1'b1};
        vt[4]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 3'd2, 1'b1};
        vt[5]  = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 3'd3, 1'b0};
        vt[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 3'd1, 1'b1};
        vt[7]  = '{3'd5, 16'h8001, 16'h0000, 16'h0002, 3'd5, 1'b0};
        vt[8]  = '{3'd6, 16'h8001, 16'h0007, 16'h4000, 3'd6, 1'b1};
        vt[9]  = '{3'd7, 16'h0003, 16'h0010, 16'h0001, 3'd0, 1'b1};
        vt[10] = '{3'd7, 16'h0010, 16'h0003, 16'h0000, 3'd7, 1'b0};
        vt[11] = '{3'd0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'd5, 1'b0};

        // ALU table program: each vector stores its result, then a flag-conditioned
        // jump skips a marker store of operand a when the condition holds
        prep16();
        emit(enc_lui(3'd6, 9'd7));
        for (int v = 0; v < 12; v++) begin
            tgt = 16'(pa + 12);
            load_const(3'd5, tgt);
            load_const(3'd1, vt[v].a);
            load_const(3'd2, vt[v].b);
            emit(enc(OP_ALU, vt[v].s, 3'd1, 3'd2, 3'd3));
            emit(enc(OP_ST, 3'd0, 3'd6, 3'd3, 3'd0));
            emit(enc(OP_JMP, vt[v].jc, 3'd5, 3'd0, 3'd0));
            emit(enc(OP_ST, 3'd0, 3'd6, 3'd1, 3'd0));
            exp_d.push_back(vt[v].exp);
            if (!vt[v].taken) exp_d.push_back(vt[v].a);
        end
        emit_halt();
        chk("reset mem_req", 32'(req16), 32'h0);
        chk("reset pc_o", 32'(pc16), 32'h0);
        reset16 = 1'b0;
        @(negedge clk);
        chk("first fetch req", 32'(req16), 32'h1);
        chk("first fetch addr", 32'(addr16), 32'h0);
        chk("first fetch we", 32'(we16), 32'h0);
        wait_writes16(wbase + exp_d.size());
        chk("alu table store count", 32'(wcnt16 - wbase), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++)
            chk_wr($sformatf("alu store %0d", i), wbase + i, 16'h0380, exp_d[i]);

        // JMP-with-link, ST and LD sequence
        prep16();
        emit(enc_lui(3'd6, 9'd7));
        load_const(3'd5, 16'h0020);
        load_const(3'd1, 16'h0003);
        load_const(3'd2, 16'h0003);
        emit(enc(OP_ALU, 3'd1, 3'd1, 3'd2, 3'd3));
        emit(enc(OP_JMP, 3'd1, 3'd5, 3'd0, 3'd7));
        emit(enc(OP_ST, 3'd0, 3'd6, 3'd1, 3'd0));
        pa = 32'h20;
        emit(enc(OP_ST, 3'd0, 3'd6, 3'd7, 3'd0));
        emit(enc_lui(3'd3, 9'd1));
        load_const(3'd4, 16'h0040);
        emit(enc(OP_ST, 3'd0, 3'd4, 3'd3, 3'd0));
        emit(enc(OP_LD, 3'd0, 3'd4, 3'd0, 3'd5));
        emit(enc(OP_ST, 3'd0, 3'd6, 3'd5, 3'd0));
        emit_halt();
        reset16 = 1'b0;
        wait_writes16(wbase + 3);
        chk("ldst store count", 32'(wcnt16 - wbase), 32'd3);
        chk_wr("jmp link r7", wbase, 16'h0380, 16'h000B);
        chk_wr("st r3", wbase + 1, 16'h0040, 16'h0080);
        chk_wr("ld r5 echo", wbase + 2, 16'h0380, 16'h0080);

        // Asynchronous reset while the core is running
        #3 reset16 = 1'b1;
        #1;
        chk("async reset pc_o", 32'(pc16), 32'h0);
        chk("async reset outs", {26'h0, req16, we16, irqack16, trap16, |addr16, |wdata16}, 32'h0);

        // Interrupt entry, handler store, RETI back to the idle loop, re-entry
        prep16();
        emit(enc_lui(3'd6, 9'd7));
        emit(enc(OP_IE, 3'd1, 3'd0, 3'd0, 3'd0));
        emit_halt();
        emit(enc(OP_JMP, 3'd7, 3'd0, 3'd0, 3'd5));
        emit(enc(OP_ST, 3'd0, 3'd6, 3'd5, 3'd0));
        emit(enc(OP_RETI, 3'd0, 3'd0, 3'd0, 3'd0));
        reset16 = 1'b0;
        repeat (60) @(negedge clk);
        irq16 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (irqack16) break;
            @(negedge clk);
        end
        chk("irq_ack pulse", 32'(irqack16), 32'h1);
        chk("irq vector pc", 32'(pc16), 32'h4);
        @(negedge clk);
        chk("irq_ack one cycle", 32'(irqack16), 32'h0);
        irq16 = 1'b0;
        wait_writes16(wbase + 1);
        chk("handler store count", 32'(wcnt16 - wbase), 32'd1);
        chk_wr("handler r5", wbase, 16'h0380, 16'h0005);
        chk("reti resume pc", 32'(pc16), 32'h3);
        irq16 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (irqack16) break;
            @(negedge clk);
        end
        chk("irq after reti", 32'(irqack16), 32'h1);
        irq16 = 1'b0;

        // Illegal opcode at 0x10 traps to 8; RETI there refetches the faulting pc
        prep16();
        emit(enc_alui(1'b0, 8'h10));
        emit(enc(OP_JMP, 3'd0, 3'd2, 3'd0, 3'd0));
        mem16[8]  = enc(OP_RETI, 3'd0, 3'd0, 3'd0, 3'd0);
        mem16[16] = 16'h000F;
        reset16 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (trap16) break;
            @(negedge clk);
        end
        chk("trap pulse", 32'(trap16), 32'h1);
        chk("trap vector pc", 32'(pc16), 32'h8);
        @(negedge clk);
        chk("trap one cycle", 32'(trap16), 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (req16) break;
            @(negedge clk);
        end
        chk("trap handler fetch", 32'(addr16), 32'h8);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (req16) break;
            @(negedge clk);
        end
        chk("epc refetch", 32'(addr16), 32'h10);
        reset16 = 1'b1;

        // DATA_W=32: 0xFFFFFFFF + 1 gives 0 with C=1 and Z=1
        mem32[0]  = 32'(enc_alui(1'b0, 8'd10));
        mem32[1]  = 32'(enc(OP_ALU, 3'd3, 3'd2, 3'd0, 3'd5));
        mem32[2]  = 32'(enc_alui(1'b1, 8'd11));
        mem32[3]  = 32'(enc(OP_ALU, 3'd1, 3'd0, 3'd2, 3'd1));
        mem32[4]  = 32'(enc(OP_ALU, 3'd0, 3'd2, 3'd1, 3'd3));
        mem32[5]  = 32'(enc(OP_ST, 3'd0, 3'd4, 3'd3, 3'd0));
        mem32[6]  = 32'(enc(OP_JMP, 3'd5, 3'd5, 3'd0, 3'd0));
        mem32[7]  = 32'(enc(OP_ST, 3'd0, 3'd4, 3'd1, 3'd0));
        mem32[10] = 32'(enc(OP_JMP, 3'd6, 3'd0, 3'd0, 3'd0));
        mem32[11] = 32'(enc(OP_JMP, 3'd7, 3'd0, 3'd0, 3'd7));
        mem32[12] = 32'(enc(OP_JMP, 3'd0, 3'd7, 3'd0, 3'd0));
        @(negedge clk);
        reset32 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (wcnt32 >= 1) break;
            @(negedge clk);
        end
        repeat (80) @(negedge clk);
        chk("w32 store count", 32'(wcnt32), 32'd1);
        chk("w32 store addr", wa32[0], 32'h0);
        chk("w32 add result", wd32[0], 32'h0);
        chk("w32 halt pc", pc32, 32'hC);
        reset32 = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
